instr_sequencer: RTL and testbench

- Upstream feeder for the lab CPU datapath/controller. Holds a small program memory of 16-bit instructions.
- On command, presents each instruction to the CPU on its `in` bus, pulses `load` and `s`, then waits for the CPU's `w` handshake before advancing to the next instruction.
- Captures the CPU's `out` and status flags after each instruction completes. A timeout watchdog flags a hung CPU.

---
 rtl/instr_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: feeds a small program memory of 16-bit instructions
// to the lab CPU one at a time, handshaking on the CPU's w signal. It
// captures the CPU result and flags after each instruction. A watchdog
// traps a hung CPU in a sticky error state.
module instr_sequencer #(
    parameter int AW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic          start,
    input  logic [AW:0]   count,
    input  logic          cpu_w,
    input  logic [15:0]   cpu_out,
    input  logic          cpu_n,
    input  logic          cpu_v,
    input  logic          cpu_z,
    output logic [15:0]   cpu_in,
    output logic          cpu_load,
    output logic          cpu_s,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] pc,
    output logic [15:0]   res_out,
    output logic [2:0]    res_flags
);
    localparam int         DEPTH    = 1 << AW;
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_KICK,
        S_WAIT_LO,
        S_WAIT_HI,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t        r_state;
    logic [15:0]   r_mem [DEPTH];
    logic [AW:0]   r_count;
    logic [7:0]    r_wdog;
    logic [15:0]   r_cpu_in;
    logic          r_cpu_load;
    logic          r_cpu_s;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_res_out;
    logic [2:0]    r_res_flags;

    logic [AW:0]   w_last_idx;
    logic          w_is_last;
    logic          w_wd_expired;

    // pc is compared against count-1 in AW+1 bits so that count = 2**AW ends
    // at the top address without pc ever wrapping.
    assign w_last_idx   = r_count - (AW+1)'(1);
    assign w_is_last    = ({1'b0, r_pc} == w_last_idx);
    assign w_wd_expired = (r_wdog == WD_LIMIT);

    // Program memory: loadable only while idle, never reset
    always_ff @(posedge clk) begin
        if (prog_we && (r_state == S_IDLE)) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Sequencer FSM with all outputs held in registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_wdog      <= '0;
            r_cpu_in    <= '0;
            r_cpu_load  <= 1'b0;
            r_cpu_s     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_pc        <= '0;
            r_res_out   <= '0;
            r_res_flags <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b1;
                        end else if (cpu_w) begin
                            r_count <= count;
                            r_pc    <= '0;
                            r_state <= S_FETCH;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    // Memory is read here, one cycle after start is accepted.
                    // A write to address 0 on the start edge is therefore the
                    // word that gets executed.
                    r_cpu_in   <= r_mem[r_pc];
                    r_cpu_load <= 1'b1;
                    r_state    <= S_KICK;
                end
                S_KICK: begin
                    r_cpu_s <= 1'b1;
                    r_wdog  <= '0;
                    r_state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    r_cpu_s    <= 1'b0;
                    r_cpu_load <= 1'b0;
                    if (!cpu_w) begin
                        r_wdog  <= '0;
                        r_state <= S_WAIT_HI;
                    end else if (w_wd_expired) begin
                        r_error <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                S_WAIT_HI: begin
                    if (cpu_w) begin
                        r_res_out   <= cpu_out;
                        r_res_flags <= {cpu_v, cpu_n, cpu_z};
                        r_state     <= S_NEXT;
                    end else if (w_wd_expired) begin
                        r_error <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (w_is_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_pc    <= r_pc + AW'(1);
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    // Trap state: only reset leaves it
                    r_error    <= 1'b1;
                    r_busy     <= 1'b1;
                    r_cpu_s    <= 1'b0;
                    r_cpu_load <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_in    = r_cpu_in;
    assign cpu_load  = r_cpu_load;
    assign cpu_s     = r_cpu_s;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign pc        = r_pc;
    assign res_out   = r_res_out;
    assign res_flags = r_res_flags;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer. The CPU is a behavioural ISA model with
// random handshake delays. Expected results come from a reference ISA
// evaluator that runs over a shadow copy of program memory. A monitor
// pops the expectations whenever the DUT kicks or completes.
module tb_instr_sequencer;
    localparam int AW    = 4;
    localparam int TO    = 64;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [15:0]   prog_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   count = '0;
    logic          cpu_w;
    logic [15:0]   cpu_out;
    logic          cpu_n, cpu_v, cpu_z;
    logic [15:0]   cpu_in;
    logic          cpu_load, cpu_s, busy, done, error;
    logic [AW-1:0] pc;
    logic [15:0]   res_out;
    logic [2:0]    res_flags;

    always #5 clk = ~clk;

    instr_sequencer #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .count(count), .cpu_w(cpu_w),
        .cpu_out(cpu_out), .cpu_n(cpu_n), .cpu_v(cpu_v), .cpu_z(cpu_z),
        .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s), .busy(busy),
        .done(done), .error(error), .pc(pc), .res_out(res_out),
        .res_flags(res_flags)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- ISA reference ----------------
    typedef struct packed {
        logic        wen;
        logic [2:0]  wa;
        logic [15:0] wv;
        logic        cen;
        logic [15:0] c;
        logic        fen;
        logic [2:0]  f;
    } isa_t;

    function automatic isa_t isa(input logic [15:0] ir, input logic [15:0] r [8]);
        isa_t o;
        logic [15:0] a, b, y;
        logic v;
        o = '0;
        a = r[ir[10:8]];
        b = r[ir[2:0]];
        case (ir[4:3])
            2'b01: b = b << 1;
            2'b10: b = b >> 1;
            2'b11: b = {b[15], b[15:1]};
            default: ;
        endcase
        if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) begin
            o.wen = 1'b1; o.wa = ir[10:8]; o.wv = {{8{ir[7]}}, ir[7:0]};
        end else if (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) begin
            o.wen = 1'b1; o.wa = ir[7:5]; o.wv = b; o.cen = 1'b1; o.c = b;
        end else if (ir[15:13] == 3'b101) begin
            v = 1'b0;
            case (ir[12:11])
                2'b00: begin y = a + b; v = (a[15] == b[15]) && (y[15] != a[15]); end
                2'b01: begin y = a - b; v = (a[15] != b[15]) && (y[15] != a[15]); end
                2'b10: y = a & b;
                default: y = ~b;
            endcase
            o.wen = 1'b1; o.wa = ir[7:5]; o.wv = y;
            o.cen = 1'b1; o.c = y;
            o.fen = 1'b1; o.f = {v, y[15], (y == 16'h0)};
        end
        return o;
    endfunction

    // ---------------- behavioural CPU ----------------
    logic [15:0] cpu_r [8];
    logic [15:0] cpu_c;
    logic [2:0]  cpu_f;
    logic        w_int = 1'b1;
    logic        force_low = 1'b0;
    logic        hang = 1'b0;

    assign cpu_w = w_int & ~force_low;

    initial begin
        logic [15:0] ir;
        isa_t o;
        for (int i = 0; i < 8; i++) cpu_r[i] = (i == 3) ? 16'd1 : 16'd0;
        cpu_c = '0; cpu_f = '0;
        cpu_out = '0; {cpu_v, cpu_n, cpu_z} = 3'b000;
        forever begin
            @(posedge clk); #1;
            if (cpu_s && !hang) begin
                ir = cpu_in;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                w_int = 1'b0;
                cpu_out = 16'($urandom);
                {cpu_v, cpu_n, cpu_z} = 3'($urandom);
                repeat ($urandom_range(2, 4)) begin @(posedge clk); #1; end
                o = isa(ir, cpu_r);
                if (o.wen) cpu_r[o.wa] = o.wv;
                if (o.cen) cpu_c = o.c;
                if (o.fen) cpu_f = o.f;
                cpu_out = cpu_c;
                {cpu_v, cpu_n, cpu_z} = cpu_f;
                w_int = 1'b1;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [15:0]   res;
        logic [2:0]    flags;
    } exp_t;

    logic [15:0]   shadow [DEPTH];
    logic [15:0]   ref_r [8];
    logic [15:0]   ref_c;
    logic [2:0]    ref_f;
    logic [15:0]   ref_res;
    logic [2:0]    ref_resf;
    logic [AW-1:0] ref_pc;
    logic [15:0]   exp_instr [$];
    exp_t          exp_res [$];
    int            s_seen = 0;
    int            done_seen = 0;
    int            run_base = 0;

    initial begin
        for (int i = 0; i < 8; i++) ref_r[i] = (i == 3) ? 16'd1 : 16'd0;
        ref_c = '0; ref_f = '0; ref_res = '0; ref_resf = '0; ref_pc = '0;
    end

    // Monitor: compare on every cpu_s kick and every done pulse
    initial begin
        logic        s_prev;
        logic [15:0] e;
        exp_t        x;
        s_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                s_prev = 1'b0;
            end else begin
                if (s_prev) chk("cpu_s_width", 32'(cpu_s), 32'd0);
                if (cpu_s && !s_prev) begin
                    s_seen++;
                    if (exp_instr.size() == 0) begin
                        chk("unexpected_cpu_s", 32'(cpu_s), 32'd0);
                    end else begin
                        e = exp_instr.pop_front();
                        chk("cpu_in", 32'(cpu_in), 32'(e));
                        chk("cpu_load_with_s", 32'(cpu_load), 32'd1);
                    end
                end
                if (done) begin
                    done_seen++;
                    if (exp_res.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        x = exp_res.pop_front();
                        chk("pc", 32'(pc), 32'(x.pc));
                        chk("res_out", 32'(res_out), 32'(x.res));
                        chk("res_flags", 32'(res_flags), 32'(x.flags));
                        chk("instr_left", 32'(exp_instr.size()), 32'd0);
                        chk("busy_after_done", 32'(busy), 32'd0);
                        $display("done: pc=%0d res_out=0x%04h flags=%03b", pc, res_out, res_flags);
                    end
                end
                s_prev = cpu_s;
            end
        end
    end

    // Push expectations for a run of cnt instructions over the shadow memory
    task automatic push_run(input int cnt, input bit expect_done);
        isa_t o;
        logic [15:0] ir;
        for (int i = 0; i < cnt; i++) begin
            ir = shadow[i];
            exp_instr.push_back(ir);
            if (expect_done) begin
                o = isa(ir, ref_r);
                if (o.wen) ref_r[o.wa] = o.wv;
                if (o.cen) ref_c = o.c;
                if (o.fen) ref_f = o.f;
            end
        end
        if (expect_done) begin
            if (cnt > 0) begin
                ref_pc = AW'(cnt - 1);
                ref_res = ref_c;
                ref_resf = ref_f;
            end
            exp_res.push_back({ref_pc, ref_res, ref_resf});
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cpu_w && !busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic start_run(input int cnt, input bit wr0, input logic [15:0] wdata, input bit expect_done);
        wait_idle();
        @(negedge clk);
        if (wr0) begin
            prog_we = 1'b1; prog_addr = '0; prog_data = wdata;
            shadow[0] = wdata;
        end
        start = 1'b1;
        count = (AW+1)'(cnt);
        s_seen = 0;
        run_base = done_seen;
        push_run(cnt, expect_done);
        @(negedge clk);
        start = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_seen > run_base) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("done_timeout", 32'(done_seen), 32'(run_base + 1));
    endtask

    task automatic run(input int cnt);
        start_run(cnt, 1'b0, 16'h0, 1'b1);
        wait_done();
    endtask

    task automatic write_mem(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        if (!busy) shadow[a] = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Assert reset from the current negedge, then check every output is zero
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        prog_we = 1'b0;
        exp_instr.delete();
        exp_res.delete();
        ref_pc = '0; ref_res = '0; ref_resf = '0;
        @(negedge clk);
        chk("rst_cpu_in", 32'(cpu_in), 32'd0);
        chk("rst_cpu_load", 32'(cpu_load), 32'd0);
        chk("rst_cpu_s", 32'(cpu_s), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_res_out", 32'(res_out), 32'd0);
        chk("rst_res_flags", 32'(res_flags), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] ins;
        ins = 16'($urandom);
        case ($urandom_range(0, 2))
            0: ins[15:11] = 5'b11010;
            1: ins[15:11] = 5'b11000;
            default: ins[15:13] = 3'b101;
        endcase
        return ins;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int base;
        bit ok;
        @(negedge clk);
        do_reset();

        // Program: plan words at 0..3, random instructions elsewhere
        write_mem(4'd0, 16'hD007);
        write_mem(4'd1, 16'hD102);
        write_mem(4'd2, 16'hA148);
        write_mem(4'd3, 16'hA9EB);
        for (int a = 4; a < DEPTH; a++) write_mem(AW'(a), rand_instr());

        // Three-instruction program
        run(3);
        chk("plan3_s_pulses", 32'(s_seen), 32'd3);
        chk("plan3_pc", 32'(pc), 32'd2);
        chk("plan3_res", 32'(res_out), 32'h0010);
        chk("plan3_flags", 32'(res_flags), 32'd0);

        // Four instructions ending in a zero-result subtract
        run(4);
        chk("plan4_res", 32'(res_out), 32'h0000);
        chk("plan4_flags", 32'(res_flags), 32'b001);

        // count = 0: done two cycles after start, no kick
        start_run(0, 1'b0, 16'h0, 1'b1);
        chk("cnt0_done_early", 32'(done), 32'd0);
        chk("cnt0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("cnt0_done", 32'(done), 32'd1);
        chk("cnt0_no_s", 32'(s_seen), 32'd0);

        // start while the CPU is not waiting is ignored
        @(negedge clk);
        force_low = 1'b1;
        @(negedge clk);
        start = 1'b1; count = 5'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("w0_start_busy", 32'(busy), 32'd0);
        end
        force_low = 1'b0;

        // Program writes while busy are dropped
        start_run(3, 1'b0, 16'h0, 1'b1);
        repeat (4) @(negedge clk);
        chk("busy_mid_run", 32'(busy), 32'd1);
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = ~shadow[1];
        @(negedge clk);
        prog_we = 1'b0;
        wait_done();
        run(3);

        // Random programs, including a full-memory run and write-on-start
        for (int it = 0; it < 10; it++) begin
            write_mem(AW'($urandom), rand_instr());
            write_mem(AW'($urandom), rand_instr());
            if (it == 5) begin
                start_run($urandom_range(1, 16), 1'b1, rand_instr(), 1'b1);
                wait_done();
            end else begin
                run((it == 3) ? 16 : $urandom_range(1, 16));
            end
        end
        chk("full_run_seen", 32'(done_seen), 32'd15);

        // Reset in WAIT_HI of the second instruction
        write_mem(4'd0, 16'hD007);
        write_mem(4'd1, 16'hD102);
        write_mem(4'd2, 16'hA148);
        write_mem(4'd3, 16'hA9EB);
        start_run(4, 1'b0, 16'h0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (s_seen >= 2 && !cpu_w) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("abort_reach_wait_hi", 32'(ok), 32'd1);
        @(negedge clk);
        base = done_seen;
        do_reset();
        repeat (10) @(negedge clk);
        chk("abort_no_done", 32'(done_seen), 32'(base));
        for (int i = 0; i < 50 && !w_int; i++) @(negedge clk);
        for (int i = 0; i < 8; i++) ref_r[i] = cpu_r[i];
        ref_c = cpu_c; ref_f = cpu_f;
        run(4);

        // Hung CPU: watchdog fires TO cycles after WAIT_LO entry
        hang = 1'b1;
        start_run(1, 1'b0, 16'h0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_s) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("hang_kick", 32'(ok), 32'd1);
        for (int n = 1; n <= TO; n++) begin
            @(negedge clk);
            if (n == TO - 1) chk("err_early", 32'(error), 32'd0);
            if (n == TO) begin
                chk("err_set", 32'(error), 32'd1);
                chk("err_busy", 32'(busy), 32'd1);
                chk("err_cpu_s", 32'(cpu_s), 32'd0);
                chk("err_cpu_load", 32'(cpu_load), 32'd0);
            end
        end
        start = 1'b1; count = 5'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("err_sticky", 32'(error), 32'd1);
            chk("err_s_low", 32'(cpu_s), 32'd0);
        end
        do_reset();
        hang = 1'b0;
        run(2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
